// File: rtl/mesh_port_arbiter.sv
// Round-robin arbiter with a single-entry output register for one mesh router output port.
// Optional per-requester saturating grant counters are built when MESH_ARB_GRANT_CNT_EN is defined.
module mesh_port_arbiter #(
    parameter int WIDTH = 35,
    parameter int NREQ  = 5,
    parameter int CNTW  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       in_valid,
    output logic [NREQ-1:0]       in_ready,
    input  logic [NREQ*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [2:0]            out_src
`ifdef MESH_ARB_GRANT_CNT_EN
    ,
    output logic [NREQ*CNTW-1:0]  grant_cnt
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]    ptr_q, ptr_d;
    logic             outValid_q, outValid_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic [2:0]       outSrc_q, outSrc_d;

    logic [PW-1:0]    win;
    logic             found;
    logic [PW:0]      idx;
    logic             space;
    logic             grant;

    // Scan requesters starting at the pointer and wrapping; the first valid one wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr_q} + (PW+1)'(k);
            if (idx >= (PW+1)'(NREQ)) begin
                idx = idx - (PW+1)'(NREQ);
            end
            if (!found && in_valid[idx[PW-1:0]]) begin
                found = 1'b1;
                win   = idx[PW-1:0];
            end
        end
    end

    assign space = !outValid_q || out_ready;
    assign grant = space && found && !rst;

    always_comb begin
        in_ready = '0;
        if (grant) begin
            in_ready[win] = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outSrc_d   = outSrc_q;
        if (grant) begin
            outValid_d = 1'b1;
            outData_d  = in_data[int'(win)*WIDTH +: WIDTH];
            outSrc_d   = 3'(win);
            ptr_d      = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);
        end else if (out_ready) begin
            outValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outSrc_q   <= '0;
        end else begin
            ptr_q      <= ptr_d;
            outValid_q <= outValid_d;
            outData_q  <= outData_d;
            outSrc_q   <= outSrc_d;
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_src   = outSrc_q;

`ifdef MESH_ARB_GRANT_CNT_EN
    logic [CNTW-1:0] cnt_q [NREQ];

    // Counters stick at all-ones rather than wrapping so a busy port never reads as idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (grant && (cnt_q[win] != '1)) begin
            cnt_q[win] <= cnt_q[win] + CNTW'(1);
        end
    end

    for (genvar g = 0; g < NREQ; g++) begin : gCnt
        assign grant_cnt[g*CNTW +: CNTW] = cnt_q[g];
    end
`endif

endmodule

// File: tb/tb_mesh_port_arbiter.sv
// Randomized scoreboard bench for mesh_port_arbiter; the reference model tracks pending
// requesters, the rotating priority pointer and output occupancy at transaction level.
module tb_mesh_port_arbiter;

    localparam int W    = 35;
    localparam int NREQ = 5;
    localparam int CNTW = 4;

    typedef struct {
        logic [2:0]   src;
        logic [W-1:0] data;
    } flit_t;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     inValid;
    logic [NREQ-1:0]     inReady;
    logic [NREQ*W-1:0]   inData;
    logic                outValid;
    logic                outReady;
    logic [W-1:0]        outData;
    logic [2:0]          outSrc;
`ifdef MESH_ARB_GRANT_CNT_EN
    logic [NREQ*CNTW-1:0] grantCnt;
    int                   mCnt [NREQ];
`endif

    int           nTests;
    int           nFail;
    flit_t        sb [$];
    int           mPtr;
    bit           mFull;
    bit           pend [NREQ];
    logic [W-1:0] pdat [NREQ];

    mesh_port_arbiter #(.WIDTH(W), .NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_data   (inData),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_data  (outData),
        .out_src   (outSrc)
`ifdef MESH_ARB_GRANT_CNT_EN
        ,
        .grant_cnt (grantCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Priority order is the pointer followed by the rest in wrap-around order.
    function automatic int pickWinner();
        int order [$];
        for (int k = 0; k < NREQ; k++) begin
            order.push_back((mPtr + k) % NREQ);
        end
        foreach (order[j]) begin
            if (pend[order[j]]) return order[j];
        end
        return -1;
    endfunction

    task automatic driveInputs();
        for (int i = 0; i < NREQ; i++) begin
            inValid[i]          = pend[i];
            inData[i*W +: W]    = pdat[i];
        end
    endtask

    // One clock of stimulus: drive, predict the grant, check combinational ready, then
    // advance the model as the upcoming rising edge will.
    task automatic applyStimulus(input bit oready);
        int              g;
        bit              grant;
        logic [NREQ-1:0] expReady;
        flit_t           f;
        @(negedge clk);
        rst      = 1'b0;
        outReady = oready;
        driveInputs();
        #1;
        g        = pickWinner();
        grant    = (!mFull || oready) && (g >= 0);
        expReady = '0;
        if (grant) expReady[g] = 1'b1;
        checkOutput("inReady", 64'(inReady), 64'(expReady));
        checkOutput("outValid", 64'(outValid), 64'(mFull));
`ifdef MESH_ARB_GRANT_CNT_EN
        for (int i = 0; i < NREQ; i++) begin
            checkOutput("grantCnt", 64'(grantCnt[i*CNTW +: CNTW]), 64'(mCnt[i]));
        end
`endif
        if (grant) begin
            f.src  = 3'(g);
            f.data = pdat[g];
            sb.push_back(f);
            pend[g] = 1'b0;
            mPtr    = (g + 1) % NREQ;
            mFull   = 1'b1;
`ifdef MESH_ARB_GRANT_CNT_EN
            if (mCnt[g] < (1 << CNTW) - 1) mCnt[g]++;
`endif
        end else if (oready) begin
            mFull = 1'b0;
        end
    endtask

    task automatic resetCycle();
        @(negedge clk);
        rst      = 1'b1;
        outReady = 1'b0;
        driveInputs();
        #1;
        checkOutput("inReady in reset", 64'(inReady), 64'(0));
        mPtr  = 0;
        mFull = 1'b0;
        sb.delete();
`ifdef MESH_ARB_GRANT_CNT_EN
        for (int i = 0; i < NREQ; i++) mCnt[i] = 0;
`endif
    endtask

    // Monitor: whatever the output register holds must be the oldest outstanding flit.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!rst && outValid) begin
                if (sb.size() == 0) begin
                    nTests++;
                    nFail++;
                    $display("[TB] FAIL unexpected flit: got src %0d data %0h, expected none", outSrc, outData);
                end else begin
                    checkOutput("outData", 64'(outData), 64'(sb[0].data));
                    if (outReady) begin
                        checkOutput("outSrc", 64'(outSrc), 64'(sb[0].src));
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        nTests   = 0;
        nFail    = 0;
        rst      = 1'b1;
        inValid  = '0;
        inData   = '0;
        outReady = 1'b0;
        mPtr     = 0;
        mFull    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0;
            pdat[i] = '0;
        end
        resetCycle();
        resetCycle();

        $display("[TB] idle after reset");
        repeat (10) applyStimulus(1'b1);
        checkOutput("reset outData", 64'(outData), 64'(0));
        checkOutput("reset outSrc", 64'(outSrc), 64'(0));

        $display("[TB] all requesters continuously valid");
        repeat (10) begin
            for (int i = 0; i < NREQ; i++) begin
                pend[i] = 1'b1;
                pdat[i] = W'(35'h100 + i);
            end
            applyStimulus(1'b1);
        end
        repeat (6) applyStimulus(1'b1);

        $display("[TB] single requester with downstream stall");
        pend[3] = 1'b1;
        pdat[3] = 35'h7_ABCD;
        repeat (4) applyStimulus(1'b0);
        repeat (2) applyStimulus(1'b1);

        $display("[TB] pointer wrap");
        pend[0] = 1'b1;
        pdat[0] = W'({$urandom, $urandom});
        pend[3] = 1'b1;
        pdat[3] = W'({$urandom, $urandom});
        repeat (3) applyStimulus(1'b1);

        $display("[TB] reset with a held flit");
        pend[1] = 1'b1;
        pdat[1] = W'({$urandom, $urandom});
        applyStimulus(1'b0);
        applyStimulus(1'b0);
        resetCycle();
        repeat (2) applyStimulus(1'b1);
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b1;
            pdat[i] = W'({$urandom, $urandom});
        end
        repeat (7) applyStimulus(1'b1);

        $display("[TB] repeated grants to requester 2");
        repeat (20) begin
            pend[2] = 1'b1;
            pdat[2] = W'({$urandom, $urandom});
            applyStimulus(1'b1);
        end
        repeat (2) applyStimulus(1'b1);

        $display("[TB] randomized traffic");
        repeat (400) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 9) < 4)) begin
                    pend[i] = 1'b1;
                    pdat[i] = W'({$urandom, $urandom});
                end
            end
            if ($urandom_range(0, 99) == 0) resetCycle();
            else applyStimulus($urandom_range(0, 9) < 7);
        end
        repeat (12) applyStimulus(1'b1);

        @(negedge clk);
        #4;
        checkOutput("scoreboard drained", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/mesh_port_arbiter.md
# mesh_port_arbiter

Round-robin arbiter and single-entry output register for one output port of a 2D-mesh router. It collects flits from the five router input directions (N, E, W, S, PE) and grants one flit per cycle to the shared output link with fair rotating priority. It sits between the router's route-compute stage and each of its five output links, so each router instantiates one per output direction. It is the synchronous-clocked counterpart of the router's output-port sharing.

## Interface
- WIDTH, 35, flit width in bits (matches mesh channel width)
- NREQ, 5, number of requesters; index 0=N, 1=E, 2=W, 3=S, 4=PE
- CNTW, 16, width of each grant counter (only used with MESH_ARB_GRANT_CNT_EN)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  NREQ  requester i has a flit on in_data slice i
- in_ready  out  NREQ  one-hot or zero; requester i's flit is taken this cycle
- in_data  in  NREQ*WIDTH  flits; slice i = in_data[i*WIDTH +: WIDTH]
- out_valid  out  1  output register holds a flit
- out_ready  in  1  downstream link accepts the flit this cycle
- out_data  out  WIDTH  registered flit
- out_src  out  3  index of the requester that supplied out_data
- grant_cnt  out  NREQ*CNTW  per-requester grant counts (only with MESH_ARB_GRANT_CNT_EN)

## Operation
- Handshakes are valid/ready. A transfer occurs on an edge where valid and ready are both 1.
- A requester must hold in_valid and its in_data slice stable until it sees in_ready. in_valid must not depend on in_ready.
- space = !out_valid || out_ready. The output register can load when it is empty or being drained in the same cycle.
- Priority pointer ptr (0..NREQ-1), reset value 0.
- Winner g is the first i with in_valid[i]=1, searching ptr, ptr+1, …, wrapping NREQ-1 to 0.
- in_ready[g] = space && any in_valid. All other in_ready bits are 0.
- On a grant:
  - out_data <= slice g; out_src <= g; out_valid <= 1
  - ptr <= (g == NREQ-1) ? 0 : g+1
- No grant with out_ready=1: out_valid <= 0. out_data and out_src hold their last values.
- No grant with out_ready=0: all state holds. out_data is stable while out_valid=1 and out_ready=0.
- No requests: ptr is unchanged.
- Simultaneous drain and load: both occur in the same cycle with no bubble.
- Reset values: out_valid=0, out_data=0, out_src=0, ptr=0, in_ready=0, grant_cnt=0.
- Reset mid-operation discards any held flit; no in_ready is asserted during rst.

## Timing
- Latency is 1 cycle: a flit granted at edge n appears on out_data after edge n.
- Throughput is 1 flit/cycle while out_ready=1 and any requester is valid.
- in_ready is combinational from in_valid, out_valid, out_ready and ptr. Every other output is registered.
- Fairness: with all NREQ requesters continuously valid and out_ready=1, each requester is granted exactly once in every NREQ consecutive grants.
- Worst-case wait for a valid requester is NREQ-1 grants to others once the output drains.

## Configuration
- MESH_ARB_GRANT_CNT_EN defined:
  - NREQ saturating counters of CNTW bits; counter i increments on each grant to i and sticks at all-ones.
  - Counters are cleared by rst and exposed on grant_cnt.
- Not defined:
  - No counters are built and the grant_cnt port is absent.
  - Arbitration behaviour is identical either way.

## Test plan
- Reset, then drive in_valid=5'b00000 for 10 cycles -> out_valid=0, in_ready=0, ptr stays 0, out_data=0.
- Drive in_valid=5'b11111 with flit i = 35'h100+i, out_ready=1 for 10 cycles -> out_src sequence 0,1,2,3,4,0,1,2,3,4; one out_valid per cycle; each out_data matches its source.
- Set in_valid[3]=1 only, data 35'h7_ABCD, out_ready=0 for 4 cycles, then 1 -> out_valid rises after 1 cycle; out_data is held constant while stalled; in_ready[3] is high only in the first cycle; exactly one transfer downstream.
- ptr=4 (after granting 3), in_valid=5'b01001 -> grant 0 (wrap), then 3; in_ready is never 2'b11-hot.
- Assert rst for one cycle while out_valid=1 and out_ready=0 -> the next cycle has out_valid=0 and ptr=0; the held flit is never delivered.
- With MESH_ARB_GRANT_CNT_EN and CNTW=4: 20 grants to requester 2 -> grant_cnt slice 2 = 4'hF (saturated); the other slices are 0.
